// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer_if
// Description : Handshake/bus bundle between the EX stage and the
//               multi-cycle RV32M divide unit.
//               master : EX stage side (drives Start/Op/operands/Flush)
//               slave  : divide unit side (drives Busy/Done/Result/StallReq)
//   Start     EX -> div  divide requested by the instruction in EX
//   Op        EX -> div  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Operand1  EX -> div  dividend (rs1, post-forwarding)
//   Operand2  EX -> div  divisor  (rs2, post-forwarding)
//   Flush     EX -> div  abort the in-flight operation
//   Busy      div -> EX  high while iterating or fixing signs
//   Done      div -> EX  one-cycle pulse, Result valid
//   Result    div -> EX  quotient or remainder
//   StallReq  div -> hazard unit, holds IF/ID/EX
// Revision    : 1.0 - initial release
// ============================================================================
interface div_sequencer_if #(
   parameter int XLEN = 32
) ();
   logic            Start;
   logic [1:0]      Op;
   logic [XLEN-1:0] Operand1;
   logic [XLEN-1:0] Operand2;
   logic            Flush;
   logic            Busy;
   logic            Done;
   logic [XLEN-1:0] Result;
   logic            StallReq;

   modport master (
      output Start, Op, Operand1, Operand2, Flush,
      input  Busy, Done, Result, StallReq
   );

   modport slave (
      input  Start, Op, Operand1, Operand2, Flush,
      output Busy, Done, Result, StallReq
   );
endinterface
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU) using a
//               radix-2 restoring datapath, one quotient bit per cycle.
//               Divide-by-zero and signed overflow complete in one cycle.
// Ports       : clk  - core clock
//               rst  - synchronous active-high reset
//               bus  - div_sequencer_if.slave (Start, Op, Operand1, Operand2,
//                      Flush in; Busy, Done, Result, StallReq out)
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
   parameter int XLEN = 32
) (
   input  wire logic          clk,
   input  wire logic          rst,
   div_sequencer_if.slave     bus
);

   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_calc = 2'd1;
   localparam logic [1:0] c_fix  = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   localparam logic [CW-1:0]   c_cnt_init = CW'(XLEN - 1);
   localparam logic [CW-1:0]   c_cnt_one  = CW'(1);
   localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      r_state;
   logic [1:0]      w_next;

   logic [CW-1:0]   r_cnt;
   logic [XLEN:0]   r_rem;      // one spare bit so the compare/subtract never overflows
   logic [XLEN-1:0] r_quo;      // holds the dividend, shifted out as quotient bits shift in
   logic [XLEN-1:0] r_dvs;
   logic            r_qneg;
   logic            r_rneg;
   logic            r_sel_rem;
   logic [XLEN-1:0] r_result;

   // ------------------------------------------------------------------------
   // Operand conditioning for the acceptance cycle
   // ------------------------------------------------------------------------
   logic            w_start_ok;
   logic            w_accept;
   logic            w_signed;
   logic            w_sign1;
   logic            w_sign2;
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;
   logic            w_div0;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;

   assign w_start_ok = bus.Start && ((r_state == c_idle) || (r_state == c_done));
   assign w_accept   = w_start_ok && !bus.Flush;

   assign w_signed = ~bus.Op[0];
   assign w_sign1  = w_signed & bus.Operand1[XLEN-1];
   assign w_sign2  = w_signed & bus.Operand2[XLEN-1];
   // Negating INT_MIN wraps back to itself, which is the correct magnitude
   // when read as unsigned.
   assign w_abs1   = w_sign1 ? (~bus.Operand1 + 1'b1) : bus.Operand1;
   assign w_abs2   = w_sign2 ? (~bus.Operand2 + 1'b1) : bus.Operand2;

   assign w_div0    = (bus.Operand2 == '0);
   assign w_ovf     = w_signed && (bus.Operand1 == c_int_min) && (bus.Operand2 == '1);
   assign w_special = w_div0 | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div0) begin
         w_special_res = bus.Op[1] ? bus.Operand1 : '1;
      end else begin
         w_special_res = bus.Op[1] ? '0 : c_int_min;
      end
   end

   // ------------------------------------------------------------------------
   // Restoring step and sign fix-up
   // ------------------------------------------------------------------------
   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_dvs_ext;
   logic [XLEN:0]   w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;

   assign w_shift   = (r_rem << 1) | {{XLEN{1'b0}}, r_quo[XLEN-1]};
   assign w_dvs_ext = {1'b0, r_dvs};
   assign w_ge      = (w_shift >= w_dvs_ext);
   assign w_diff    = w_shift - w_dvs_ext;

   assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = r_rneg ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      if (bus.Flush) begin
         w_next = c_idle;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  w_next = w_special ? c_done : c_calc;
               end
            end
            c_calc: begin
               if (r_cnt == '0) begin
                  w_next = c_fix;
               end
            end
            c_fix: begin
               w_next = c_done;
            end
            c_done: begin
               if (w_accept) begin
                  w_next = w_special ? c_done : c_calc;
               end else begin
                  w_next = c_idle;
               end
            end
            default: begin
               w_next = c_idle;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      bus.Busy     = (r_state == c_calc) || (r_state == c_fix);
      bus.Done     = (r_state == c_done);
      // Low in DONE so the instruction advances together with its result.
      bus.StallReq = w_start_ok || (r_state == c_calc) || (r_state == c_fix);
   end

   assign bus.Result = r_result;

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_sel_rem <= 1'b0;
         r_result  <= '0;
      end else if (!bus.Flush) begin
         if (w_accept) begin
            r_sel_rem <= bus.Op[1];
            r_qneg    <= w_sign1 ^ w_sign2;
            r_rneg    <= w_sign1;
            r_quo     <= w_abs1;
            r_dvs     <= w_abs2;
            r_rem     <= '0;
            r_cnt     <= c_cnt_init;
            if (w_special) begin
               r_result <= w_special_res;
            end
         end else if (r_state == c_calc) begin
            r_rem <= w_ge ? w_diff : w_shift;
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt - c_cnt_one;
         end else if (r_state == c_fix) begin
            r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. Expected results are
//               queued when an operation is launched and compared when Done
//               pulses; latency, flush, held-Start and reset behaviour are
//               checked from the driving process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_sequencer_if #(.XLEN(32)) bus ();

   div_sequencer #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_done   = 0;
   int          last_done_cyc = 0;
   logic [31:0] sb[$];
   logic [31:0] last_exp = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'h0) begin
         r = op[1] ? a : 32'hFFFF_FFFF;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = op[1] ? 32'h0 : 32'h8000_0000;
      end else begin
         case (op)
            2'b00:   r = $signed(a) / $signed(b);
            2'b01:   r = a / b;
            2'b10:   r = $signed(a) % $signed(b);
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Scoreboard consumer: every Done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.Done === 1'b1) begin
         n_done++;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            check("result", bus.Result, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start    = 1'b1;
      bus.Op       = op;
      bus.Operand1 = a;
      bus.Operand2 = b;
      sb.push_back(model(op, a, b));
      last_exp = model(op, a, b);
   endtask

   // Returns at negedge+1 of the cycle in which Done was seen.
   task automatic wait_done(input int budget);
      int d0;
      d0 = n_done;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_done != d0) return;
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int t0;
      drive_start(op, a, b);
      tick();
      bus.Start = 1'b0;
      t0 = cyc;
      wait_done(40);
      check("latency", 32'(last_done_cyc - t0), is_special(op, a, b) ? 32'd0 : 32'd33);
      tick();
   endtask

   initial begin
      int t0;
      int d0;
      int bad;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      bus.Start    = 1'b0;
      bus.Op       = 2'b00;
      bus.Operand1 = 32'h0;
      bus.Operand2 = 32'h0;
      bus.Flush    = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_busy",   32'(bus.Busy),     32'd0);
      check("reset_done",   32'(bus.Done),     32'd0);
      check("reset_result", bus.Result,        32'd0);
      check("reset_stall",  32'(bus.StallReq), 32'd0);

      // DIV 100/7 with cycle-by-cycle handshake checks
      drive_start(2'b00, 32'd100, 32'd7);
      #1;
      check("stall_accept", 32'(bus.StallReq), 32'd1);
      tick();
      bus.Start = 1'b0;
      bad = 0;
      for (int i = 0; i < 33; i++) begin
         if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.StallReq !== 1'b1) bad++;
         tick();
      end
      check("busy_window", 32'(bad), 32'd0);
      check("done_t34",    32'(bus.Done),     32'd1);
      check("busy_t34",    32'(bus.Busy),     32'd0);
      check("stall_t34",   32'(bus.StallReq), 32'd0);
      tick();
      check("done_pulse",  32'(bus.Done),     32'd0);
      check("result_hold", bus.Result,        32'd14);

      // Directed normal and special cases
      run(2'b10, 32'hFFFF_FFEC, 32'd6);
      run(2'b01, 32'hFFFF_FFFF, 32'd2);
      run(2'b11, 32'hFFFF_FFFF, 32'd16);
      run(2'b01, 32'd5,         32'd0);
      run(2'b10, 32'd5,         32'd0);
      run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b00, 32'hFFFF_FF9C, 32'd7);
      run(2'b10, 32'd100,       32'hFFFF_FFF9);

      // Random operations
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 30);
         run(rop, ra, rb);
      end

      // Start together with Flush is ignored
      bus.Start    = 1'b1;
      bus.Flush    = 1'b1;
      bus.Operand1 = 32'd50;
      bus.Operand2 = 32'd5;
      tick();
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      check("flush_start_busy", 32'(bus.Busy), 32'd0);
      check("flush_start_done", 32'(bus.Done), 32'd0);
      tick();

      // Flush mid-operation
      d0 = n_done;
      begin
         logic [31:0] held;
         held = last_exp;
         drive_start(2'b00, 32'd1000, 32'd3);
         tick();
         bus.Start = 1'b0;
         repeat (9) tick();
         bus.Flush = 1'b1;
         tick();
         bus.Flush = 1'b0;
         sb.delete();
         check("flush_busy",   32'(bus.Busy), 32'd0);
         check("flush_done",   32'(bus.Done), 32'd0);
         check("flush_result", bus.Result,    held);
         check("flush_no_done", 32'(n_done - d0), 32'd0);
      end
      tick();
      run(2'b00, 32'd9, 32'd3);

      // Start held through Busy is ignored; a Start in DONE is accepted
      drive_start(2'b00, 32'd100, 32'd7);
      tick();
      t0 = cyc;
      bus.Operand1 = 32'd55;
      bus.Operand2 = 32'd5;
      wait_done(40);
      check("held_latency", 32'(last_done_cyc - t0), 32'd33);
      drive_start(2'b00, 32'd8, 32'd2);
      tick();
      bus.Start = 1'b0;
      t0 = cyc;
      check("redone_busy", 32'(bus.Busy), 32'd1);
      wait_done(40);
      check("redone_latency", 32'(last_done_cyc - t0), 32'd33);
      tick();

      // Reset mid-operation
      drive_start(2'b11, 32'd12345, 32'd10);
      tick();
      bus.Start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("rst_busy",   32'(bus.Busy), 32'd0);
      check("rst_done",   32'(bus.Done), 32'd0);
      check("rst_result", bus.Result,    32'd0);
      d0 = n_done;
      repeat (40) tick();
      check("rst_no_done", 32'(n_done - d0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
